// File: rtl/fifo_rd_pkg.sv
// Shared types and default sizes for the FIFO read-side controller.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_t;

  localparam int unsigned FIFO_WIDTH_DEF = 16;
  localparam int unsigned SKID_DEPTH_DEF = 4;
  localparam int unsigned CNT_WIDTH_DEF  = 16;

endpackage

// File: rtl/fifo_rd_skid.sv
// Small circular skid buffer that absorbs the FIFO read latency and downstream stalls.
module fifo_rd_skid import fifo_rd_pkg::*; #(
  parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned DEPTH = SKID_DEPTH_DEF,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    cnt
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;

  // Wrap modulo DEPTH so non-power-of-two depths also work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (!push && pop) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign cnt   = cnt_q;

  skid_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !clear && (cnt_q == CW'(DEPTH))));
  skid_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CW'(DEPTH));
  skid_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !clear && (cnt_q == '0)));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller: pops the FIFO, hides its read latency, streams words downstream.
// Optional delivered-word counter (o_word_cnt) is enabled by defining FIFO_RD_CNT_EN.
module fifo_rd_ctrl import fifo_rd_pkg::*; #(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned SKID_DEPTH = SKID_DEPTH_DEF
`ifdef FIFO_RD_CNT_EN
  ,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_pop,
  output logic [FIFO_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  input  logic                  i_en,
  input  logic                  i_flush,
  output logic                  o_flush_done,
  output logic                  o_busy
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  o_word_cnt
`endif
);

  localparam int unsigned CW = $clog2(SKID_DEPTH + 1);

  rd_state_t     state_q;
  logic          pop_q;
  logic [CW-1:0] buf_cnt;
  logic          credit_ok;
  logic          xfer;
  logic          flush_start;
  logic          skid_push;

  // Count in-flight pops as occupied slots so the skid can never overflow.
  assign credit_ok = (32'(buf_cnt) + 32'(pop_q)) < SKID_DEPTH;

  always_comb begin
    o_fifo_pop = 1'b0;
    case (state_q)
      RUN:     o_fifo_pop = i_en && !i_fifo_empty && credit_ok;
      FLUSH:   o_fifo_pop = !i_fifo_empty;
      default: o_fifo_pop = 1'b0;
    endcase
  end

  assign o_valid      = (state_q != FLUSH) && (buf_cnt != '0);
  assign xfer         = o_valid && i_ready;
  assign flush_start  = i_flush && (state_q != FLUSH);
  assign skid_push    = pop_q && (state_q == RUN);
  assign o_flush_done = (state_q == FLUSH) && i_fifo_empty && !pop_q;
  assign o_busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pop_q   <= 1'b0;
    end else begin
      pop_q <= o_fifo_pop;
      case (state_q)
        IDLE: begin
          if (i_flush) begin
            state_q <= FLUSH;
          end else if (i_en) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (i_flush) begin
            state_q <= FLUSH;
          end else if (!i_en && (buf_cnt == '0) && !pop_q) begin
            state_q <= IDLE;
          end
        end
        FLUSH: begin
          if (i_fifo_empty && !pop_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fifo_rd_skid #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (skid_push),
    .wdata (i_fifo_data),
    .pop   (xfer),
    .clear (flush_start),
    .rdata (o_data),
    .cnt   (buf_cnt)
  );

`ifdef FIFO_RD_CNT_EN
  logic [CNT_WIDTH-1:0] word_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
    end else if (flush_start) begin
      word_cnt_q <= '0;
    end else if (xfer) begin
      word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign o_word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural FIFO (one-cycle read latency).
module tb_fifo_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] fifo_data = '0;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [15:0] data;
  logic        valid;
  logic        ready = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        busy;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] word_cnt;
`endif

  always #5 clk = ~clk;

  fifo_rd_ctrl u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_fifo_data  (fifo_data),
    .i_fifo_empty (fifo_empty),
    .o_fifo_pop   (fifo_pop),
    .o_data       (data),
    .o_valid      (valid),
    .i_ready      (ready),
    .i_en         (en),
    .i_flush      (flush),
    .o_flush_done (flush_done),
    .o_busy       (busy)
`ifdef FIFO_RD_CNT_EN
    ,
    .o_word_cnt   (word_cnt)
`endif
  );

  // Behavioural FIFO: data appears the cycle after a pop.
  logic [15:0] fmem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_pop && !fifo_empty) begin
      fifo_data <= fmem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitor: log transfers, pops, flush pulses and busy falls by cycle number.
  int          cyc = 0;
  logic [15:0] got_q[$];
  int          val_cyc[$];
  int          pop_cyc[$];
  int          fd_cnt = 0;
  int          busy_low_cyc = -1;
  logic        busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) begin
        got_q.push_back(data);
        val_cyc.push_back(cyc);
      end
      if (fifo_pop) pop_cyc.push_back(cyc);
      if (flush_done) fd_cnt <= fd_cnt + 1;
      if (busy_prev && !busy) busy_low_cyc <= cyc;
      busy_prev <= busy;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int n, input logic [15:0] base, input logic [15:0] inc);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr] = base + 16'(i) * inc;
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic wait_words(input int target, input int limit);
    for (int k = 0; k < limit && got_q.size() < target; k++) step();
  endtask

  // Raise en until n pops have been seen, then drop it right after the next edge.
  task automatic pop_n(input int n);
    int pb;
    pb = pop_cyc.size();
    en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      sample();
      if (pop_cyc.size() - pb >= n) break;
    end
    step();
    en = 1'b0;
  endtask

  function automatic logic [15:0] hex_word(input int i);
    return 16'(32'h1111 * (i + 1));
  endfunction

  initial begin
    int gb;
    int pb;
    int fb;
    int n;

    // Reset values
    #2;
    check_eq("rst_pop", 32'(fifo_pop), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_data", 32'(data), 32'd0);
    check_eq("rst_fdone", 32'(flush_done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // 1: preloaded stream at full rate
    load(8, 16'h1111, 16'h1111);
    gb = got_q.size();
    pb = pop_cyc.size();
    ready = 1'b1;
    en = 1'b1;
    wait_words(gb + 8, 60);
    repeat (4) step();
    check_eq("t1_words", 32'(got_q.size() - gb), 32'd8);
    check_eq("t1_pops", 32'(pop_cyc.size() - pb), 32'd8);
    if (got_q.size() - gb >= 8) begin
      check_eq("t1_latency", 32'(val_cyc[gb] - pop_cyc[pb]), 32'd2);
      for (int i = 0; i < 8; i++) begin
        check_eq("t1_data", 32'(got_q[gb + i]), 32'(hex_word(i)));
        check_eq("t1_rate", 32'(val_cyc[gb + i] - val_cyc[gb]), 32'(i));
      end
    end
    sample();
    check_eq("t1_pop_idle", 32'(fifo_pop), 32'd0);

    // 2: downstream stalled, skid fills, then drains in order
    step();
    ready = 1'b0;
    load(8, 16'h1111, 16'h1111);
    gb = got_q.size();
    pb = pop_cyc.size();
    repeat (10) step();
    check_eq("t2_pops_stalled", 32'(pop_cyc.size() - pb), 32'd4);
    sample();
    check_eq("t2_valid", 32'(valid), 32'd1);
    check_eq("t2_head", 32'(data), 32'h1111);
    repeat (3) step();
    sample();
    check_eq("t2_head_stable", 32'(data), 32'h1111);
    step();
    ready = 1'b1;
    wait_words(gb + 8, 60);
    repeat (3) step();
    check_eq("t2_words", 32'(got_q.size() - gb), 32'd8);
    check_eq("t2_pops", 32'(pop_cyc.size() - pb), 32'd8);
    n = (got_q.size() - gb < 8) ? got_q.size() - gb : 8;
    for (int i = 0; i < n; i++) check_eq("t2_data", 32'(got_q[gb + i]), 32'(hex_word(i)));
`ifdef FIFO_RD_CNT_EN
    check_eq("t2_word_cnt", 32'(word_cnt), 32'd16);
`endif

    // 3: random back-pressure over 200 words
    load(200, 16'h0005, 16'h0025);
    gb = got_q.size();
    for (int k = 0; k < 3000 && got_q.size() < gb + 200; k++) begin
      step();
      ready = 1'($urandom_range(0, 1));
    end
    step();
    ready = 1'b1;
    repeat (3) step();
    check_eq("t3_words", 32'(got_q.size() - gb), 32'd200);
    n = (got_q.size() - gb < 200) ? got_q.size() - gb : 200;
    for (int i = 0; i < n; i++) begin
      check_eq("t3_data", 32'(got_q[gb + i]), 32'(16'h0005 + 16'(i) * 16'h0025));
    end

    // 4: en dropped right after the third pop
    en = 1'b0;
    for (int k = 0; k < 20 && busy; k++) step();
    check_eq("t4_idle", 32'(busy), 32'd0);
    load(8, 16'hA001, 16'h0001);
    gb = got_q.size();
    pb = pop_cyc.size();
    pop_n(3);
    repeat (8) step();
    check_eq("t4_pops", 32'(pop_cyc.size() - pb), 32'd3);
    check_eq("t4_words", 32'(got_q.size() - gb), 32'd3);
    n = (got_q.size() - gb < 3) ? got_q.size() - gb : 3;
    for (int i = 0; i < n; i++) check_eq("t4_data", 32'(got_q[gb + i]), 32'(16'hA001 + 16'(i)));
    check_eq("t4_busy", 32'(busy), 32'd0);
    if (val_cyc.size() > 0) begin
      check_eq("t4_busy_fall", 32'(busy_low_cyc - val_cyc[val_cyc.size() - 1]), 32'd2);
    end

    // 5: flush with 2 buffered and 5 in the FIFO
    ready = 1'b0;
    pop_n(2);
    repeat (3) step();
    sample();
    check_eq("t5_pre_valid", 32'(valid), 32'd1);
    check_eq("t5_pre_head", 32'(data), 32'hA004);
    load(2, 16'hB001, 16'h0001);
    gb = got_q.size();
    pb = pop_cyc.size();
    fb = fd_cnt;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    ready = 1'b1;
    sample();
    check_eq("t5_valid_off", 32'(valid), 32'd0);
    check_eq("t5_busy_on", 32'(busy), 32'd1);
    repeat (15) step();
    check_eq("t5_pops", 32'(pop_cyc.size() - pb), 32'd5);
    check_eq("t5_fdone", 32'(fd_cnt - fb), 32'd1);
    check_eq("t5_no_words", 32'(got_q.size() - gb), 32'd0);
    check_eq("t5_busy_off", 32'(busy), 32'd0);
    check_eq("t5_empty", 32'(fifo_empty), 32'd1);
`ifdef FIFO_RD_CNT_EN
    check_eq("t5_word_cnt", 32'(word_cnt), 32'd0);
`endif

    // 6: asynchronous reset mid-stream
    load(8, 16'hC001, 16'h0001);
    ready = 1'b1;
    en = 1'b1;
    repeat (3) step();
    sample();
    check_eq("t6_pop_pre", 32'(fifo_pop), 32'd1);
    check_eq("t6_valid_pre", 32'(valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t6_valid", 32'(valid), 32'd0);
    check_eq("t6_pop", 32'(fifo_pop), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_data", 32'(data), 32'd0);
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    sample();
    check_eq("t6_post_valid", 32'(valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
